seven_seg_scanner: RTL

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

---
 rtl/seven_seg_scanner_if.sv | 37 +++
 rtl/seven_seg_scanner.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner_if.sv
// rtl/seven_seg_scanner_if.sv - display data and scan-output bundle for seven_seg_scanner
//
// Purpose: groups the host-side load signals and the multiplexed display
// outputs of the scanner into one interface.
// Signals:
//   value_in[15:0]  four hex nibbles, nibble k -> digit k (digit 0 rightmost)
//   blank_in[3:0]   per-digit blank, 1 forces the digit's segments off
//   dp_in[3:0]      per-digit decimal point, 1 lights the point
//   load            single-cycle strobe capturing value_in/blank_in/dp_in
//   an[3:0]         digit anodes, active-low, at most one low
//   seg[6:0]        segments {g,f,e,d,c,b,a}, active-low
//   dp              decimal point, active-low
//   pending         loaded data is waiting for the next commit point
//   frame_done      one-cycle pulse after every commit point
// Modports: master = host/driver side, slave = scanner side.

interface seven_seg_scanner_if;
  logic [15:0] value_in;
  logic [3:0]  blank_in;
  logic [3:0]  dp_in;
  logic        load;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        pending;
  logic        frame_done;

  modport master (
    output value_in, blank_in, dp_in, load,
    input  an, seg, dp, pending, frame_done
  );

  modport slave (
    input  value_in, blank_in, dp_in, load,
    output an, seg, dp, pending, frame_done
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - four-digit multiplexed seven-segment scanner with frame-synchronous update
//
// Purpose: scans four hex digits over a common-anode display. Each digit is
// held for 2^REFRESH_W cycles, the first DEAD_CYCLES of which keep all anodes
// off to avoid ghosting. New data is staged in pending registers and copied
// into the displayed shadow only at the end of digit 3, so a frame never
// mixes old and new data.
// Ports:
//   clk    system clock, all registers update on the rising edge
//   rst_n  synchronous active-low reset
//   bus    seven_seg_scanner_if.slave (load inputs, display outputs)

module seven_seg_scanner #(
  parameter int REFRESH_W   = 17,
  parameter int DEAD_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seven_seg_scanner_if.slave   bus
);

  localparam logic [REFRESH_W-1:0] CNT_MAX = '1;
  localparam logic [REFRESH_W-1:0] DEAD_L  = REFRESH_W'(DEAD_CYCLES);

  // Active-high gfedcba font; inverted when driven onto seg.
  function automatic logic [6:0] hex_font(input logic [3:0] n);
    case (n)
      4'h0: hex_font = 7'h3F;
      4'h1: hex_font = 7'h06;
      4'h2: hex_font = 7'h5B;
      4'h3: hex_font = 7'h4F;
      4'h4: hex_font = 7'h66;
      4'h5: hex_font = 7'h6D;
      4'h6: hex_font = 7'h7D;
      4'h7: hex_font = 7'h07;
      4'h8: hex_font = 7'h7F;
      4'h9: hex_font = 7'h6F;
      4'hA: hex_font = 7'h77;
      4'hB: hex_font = 7'h7C;
      4'hC: hex_font = 7'h39;
      4'hD: hex_font = 7'h5E;
      4'hE: hex_font = 7'h79;
      default: hex_font = 7'h71;
    endcase
  endfunction

  logic [REFRESH_W-1:0] cnt_q, cnt_d;
  logic [1:0]           idx_q, idx_d;
  logic [15:0]          pval_q, pval_d, sval_q, sval_d;
  logic [3:0]           pblank_q, pblank_d, sblank_q, sblank_d;
  logic [3:0]           pdp_q, pdp_d, sdp_q, sdp_d;
  logic                 pending_q, pending_d;
  logic                 fd_q, fd_d;
  logic [3:0]           an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic                 commit;
  logic [3:0]           nib;

  always_comb begin
    cnt_d     = cnt_q + REFRESH_W'(1);
    idx_d     = (cnt_q == CNT_MAX) ? idx_q + 2'd1 : idx_q;
    pval_d    = pval_q;
    pblank_d  = pblank_q;
    pdp_d     = pdp_q;
    sval_d    = sval_q;
    sblank_d  = sblank_q;
    sdp_d     = sdp_q;
    pending_d = pending_q;
    commit    = (idx_q == 2'd3) && (cnt_q == CNT_MAX);
    fd_d      = commit;
    nib       = sval_q[{idx_q, 2'b00} +: 4];

    // A load landing on the commit point bypasses staging entirely.
    if (bus.load) begin
      if (commit) begin
        sval_d    = bus.value_in;
        sblank_d  = bus.blank_in;
        sdp_d     = bus.dp_in;
        pending_d = 1'b0;
      end else begin
        pval_d    = bus.value_in;
        pblank_d  = bus.blank_in;
        pdp_d     = bus.dp_in;
        pending_d = 1'b1;
      end
    end else if (commit && pending_q) begin
      sval_d    = pval_q;
      sblank_d  = pblank_q;
      sdp_d     = pdp_q;
      pending_d = 1'b0;
    end

    if (cnt_q < DEAD_L) begin
      an_d  = 4'hF;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end else begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = sblank_q[idx_q] ? 7'h7F : ~hex_font(nib);
      dp_d  = sblank_q[idx_q] ? 1'b1  : ~sdp_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      pval_q    <= '0;
      pblank_q  <= '0;
      pdp_q     <= '0;
      sval_q    <= '0;
      sblank_q  <= '0;
      sdp_q     <= '0;
      pending_q <= 1'b0;
      fd_q      <= 1'b0;
      an_q      <= 4'hF;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pval_q    <= pval_d;
      pblank_q  <= pblank_d;
      pdp_q     <= pdp_d;
      sval_q    <= sval_d;
      sblank_q  <= sblank_d;
      sdp_q     <= sdp_d;
      pending_q <= pending_d;
      fd_q      <= fd_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.pending    = pending_q;
  assign bus.frame_done = fd_q;

endmodule
